// File: rtl/riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_core
// Description : Multicycle RV subset core (add/sub/and/or, addi, ld/sd, beq/bne)
//               with request/ack memories; RISCV_PERF_COUNTERS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic            retire,
    output logic            halt
`ifdef RISCV_PERF_COUNTERS_EN
    ,
    output logic [63:0]     cycle_count,
    output logic [63:0]     instret_count
`endif
);

    localparam int         c_ridx_w = $clog2(NREGS);
    localparam logic [2:0] c_ls_f3  = (XLEN == 64) ? 3'b011 : 3'b010;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t                r_state;
    logic [XLEN-1:0]       r_pc, r_a, r_b, r_imm, r_aluout, r_mdr;
    logic [31:0]           r_ir;
    logic [XLEN-1:0]       r_regs [NREGS];
    logic                  r_imem_req, r_dmem_req, r_dmem_we, r_halt;

    logic [6:0]            w_opcode, w_f7;
    logic [2:0]            w_f3;
    logic [c_ridx_w-1:0]   w_rs1, w_rs2, w_rd;
    logic                  w_is_r, w_is_addi, w_is_ld, w_is_st, w_is_br, w_supported;
    logic [XLEN-1:0]       w_imm, w_alu, w_pc4, w_rs1_val, w_rs2_val;
    logic                  w_taken;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_rd     = r_ir[7  +: c_ridx_w];
    assign w_rs1    = r_ir[15 +: c_ridx_w];
    assign w_rs2    = r_ir[20 +: c_ridx_w];

    assign w_is_r      = (w_opcode == 7'b0110011) &&
                         (((w_f3 == 3'b000) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000))) ||
                          (((w_f3 == 3'b110) || (w_f3 == 3'b111)) && (w_f7 == 7'b0000000)));
    assign w_is_addi   = (w_opcode == 7'b0010011) && (w_f3 == 3'b000);
    assign w_is_ld     = (w_opcode == 7'b0000011) && (w_f3 == c_ls_f3);
    assign w_is_st     = (w_opcode == 7'b0100011) && (w_f3 == c_ls_f3);
    assign w_is_br     = (w_opcode == 7'b1100011) && (w_f3[2:1] == 2'b00);
    assign w_supported = w_is_r | w_is_addi | w_is_ld | w_is_st | w_is_br;

    assign w_imm = w_is_st ? {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]} :
                   w_is_br ? {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0} :
                             {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};

    assign w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

    assign w_alu = !w_is_r           ? r_a + r_imm :
                   (w_f3 == 3'b111)  ? r_a & r_b   :
                   (w_f3 == 3'b110)  ? r_a | r_b   :
                   r_ir[30]          ? r_a - r_b   : r_a + r_b;

    // f3[0] distinguishes bne from beq
    assign w_taken = (r_a == r_b) ^ w_f3[0];
    assign w_pc4   = r_pc + XLEN'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_aluout   <= '0;
            r_mdr      <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_halt     <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_a   <= w_rs1_val;
                    r_b   <= w_rs2_val;
                    r_imm <= w_imm;
                    if (w_supported) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_HALT;
                        r_halt  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    if (w_is_br) begin
                        r_pc       <= w_taken ? r_pc + r_imm : w_pc4;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end else if (w_is_ld || w_is_st) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_is_st;
                        r_state    <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_pc       <= w_pc4;
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != '0) r_regs[w_rd] <= w_is_ld ? r_mdr : r_aluout;
                    r_pc       <= w_pc4;
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Store completion depends on the ack of the same cycle, so retire is decoded
    assign retire     = (r_state == S_WB) ||
                        ((r_state == S_EXEC) && w_is_br) ||
                        ((r_state == S_MEM) && r_dmem_req && r_dmem_we && dmem_ack);
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_aluout;
    assign dmem_wdata = r_b;
    assign pc_out     = r_pc;
    assign halt       = r_halt;

`ifdef RISCV_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (r_state != S_HALT) cycle_count <= cycle_count + 64'd1;
            if (retire) instret_count <= instret_count + 64'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_multicycle_core
// Description : Scoreboard bench: directed program, retire/dmem queues, resets.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_multicycle_core;

    logic        clk, reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halt;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
    logic [31:0] imem_rdata;
`ifdef RISCV_PERF_COUNTERS_EN
    logic [63:0] cycle_count, instret_count;
`endif

    riscv_multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'h100)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .retire(retire), .halt(halt)
`ifdef RISCV_PERF_COUNTERS_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [63:0] pc; int gap;} ret_t;
    typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata;} mem_t;
    ret_t ret_q[$];
    mem_t mem_q[$];

    logic [31:0] imem [logic [63:0]];
    logic [63:0] dmem [logic [63:0]];
    int compared = 0, failed = 0;
    int cyc = 0, last_ret = 0, dcnt = 0;
    logic mon_en = 1'b0, dmem_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ret(input logic [63:0] pc, input int gap);
        ret_q.push_back('{pc: pc, gap: gap});
    endtask

    task automatic push_mem(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
        mem_q.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0; else cyc <= cyc + 1;

    // Memory responders: zero-wait except a 3-cycle stall for address 0x48
    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack   = imem_req;
            imem_rdata = imem.exists(imem_addr) ? imem[imem_addr] : 32'hFFFF_FFFF;
            if (dmem_req && !dmem_stall) begin
                if (dcnt == ((dmem_addr == 64'h48) ? 3 : 0)) begin
                    dmem_ack = 1'b1;
                    dcnt     = 0;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : 64'h0;
                end else begin
                    dmem_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                dcnt     = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT retires or completes a data access
    initial begin
        logic        prev_req, stable;
        logic [63:0] cap_addr, cap_wdata;
        logic        cap_we;
        ret_t        r;
        mem_t        m;
        prev_req = 1'b0; stable = 1'b1; cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            check("req_exclusive", {63'd0, imem_req & dmem_req}, 64'd0);
            if (mon_en) begin
                if (retire) begin
                    if (ret_q.size() == 0) begin
                        compared++; failed++;
                        $display("FAIL retire_extra: got retire at pc %h expected none", pc_out);
                    end else begin
                        r = ret_q.pop_front();
                        check("retire_pc", pc_out, r.pc);
                        check("retire_gap", 64'(cyc - last_ret), 64'(r.gap));
                    end
                    last_ret = cyc;
                end
                if (dmem_req) begin
                    if (!prev_req) begin
                        cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata; stable = 1'b1;
                    end else if (cap_addr !== dmem_addr || cap_we !== dmem_we || cap_wdata !== dmem_wdata) begin
                        stable = 1'b0;
                    end
                    if (dmem_ack) begin
                        if (mem_q.size() == 0) begin
                            compared++; failed++;
                            $display("FAIL dmem_extra: got access at %h expected none", dmem_addr);
                        end else begin
                            m = mem_q.pop_front();
                            check("dmem_we", {63'd0, dmem_we}, {63'd0, m.we});
                            check("dmem_addr", dmem_addr, m.addr);
                            if (m.we) check("dmem_wdata", dmem_wdata, m.wdata);
                            check("dmem_stable", {63'd0, stable}, 64'd1);
                        end
                    end
                end
                prev_req = dmem_req && !dmem_ack;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, act;
        reset = 1'b0;
        imem[64'h100] = 32'h00500093; // addi x1,x0,5
        imem[64'h104] = 32'h00700113; // addi x2,x0,7
        imem[64'h108] = 32'h002081B3; // add  x3,x1,x2
        imem[64'h10C] = 32'h40208233; // sub  x4,x1,x2
        imem[64'h110] = 32'h00303023; // sd   x3,0(x0)
        imem[64'h114] = 32'h00403423; // sd   x4,8(x0)
        imem[64'h118] = 32'h04000093; // addi x1,x0,0x40
        imem[64'h11C] = 32'h0030B423; // sd   x3,8(x1)
        imem[64'h120] = 32'h0080B283; // ld   x5,8(x1)
        imem[64'h124] = 32'h00503823; // sd   x5,16(x0)
        imem[64'h128] = 32'h0020F333; // and  x6,x1,x2
        imem[64'h12C] = 32'h0020E3B3; // or   x7,x1,x2
        imem[64'h130] = 32'h00603C23; // sd   x6,24(x0)
        imem[64'h134] = 32'h02703023; // sd   x7,32(x0)
        imem[64'h138] = 32'hEE0004E3; // beq  x0,x0,-0x118 -> 0x20
        imem[64'h020] = 32'h00108863; // beq  x1,x1,+16 -> 0x30
        imem[64'h030] = 32'h00109863; // bne  x1,x1,+16 -> 0x34
        imem[64'h034] = 32'h00900013; // addi x0,x0,9
        imem[64'h038] = 32'h02003423; // sd   x0,40(x0)
        imem[64'h03C] = 32'hFFFFFFFF; // unsupported

        push_ret(64'h100, 4); push_ret(64'h104, 4); push_ret(64'h108, 4); push_ret(64'h10C, 4);
        push_ret(64'h110, 4); push_ret(64'h114, 4); push_ret(64'h118, 4); push_ret(64'h11C, 7);
        push_ret(64'h120, 8); push_ret(64'h124, 4); push_ret(64'h128, 4); push_ret(64'h12C, 4);
        push_ret(64'h130, 4); push_ret(64'h134, 4); push_ret(64'h138, 3); push_ret(64'h020, 3);
        push_ret(64'h030, 3); push_ret(64'h034, 4); push_ret(64'h038, 4);
        push_mem(1'b1, 64'h00, 64'd12);
        push_mem(1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFE);
        push_mem(1'b1, 64'h48, 64'd12);
        push_mem(1'b0, 64'h48, 64'd0);
        push_mem(1'b1, 64'h10, 64'd12);
        push_mem(1'b1, 64'h18, 64'd0);
        push_mem(1'b1, 64'h20, 64'h47);
        push_mem(1'b1, 64'h28, 64'd0);

        #12;
        check("rst_imem_req", {63'd0, imem_req}, 64'd0);
        check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        check("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_halt", {63'd0, halt}, 64'd0);
        check("rst_pc", pc_out, 64'h100);

        @(negedge clk);
        reset = 1'b1; last_ret = 0; mon_en = 1'b1;
        @(posedge clk); #1;
        check("first_imem_req", {63'd0, imem_req}, 64'd1);
        check("first_imem_addr", imem_addr, 64'h100);

        n = 0;
        while (!halt && n < 400) begin @(posedge clk); #1; n++; end
        check("halt_reached", {63'd0, halt}, 64'd1);
        check("ret_q_drained", 64'(ret_q.size()), 64'd0);
        check("mem_q_drained", 64'(mem_q.size()), 64'd0);

        act = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (imem_req || dmem_req || retire) act++;
        end
        check("halt_quiet", 64'(act), 64'd0);
        check("halt_pc", pc_out, 64'h3C);
        mon_en = 1'b0;

        @(negedge clk); #2;
        reset = 1'b0; #1;
        check("reset_clears_halt", {63'd0, halt}, 64'd0);
        check("reset_pc_async", pc_out, 64'h100);

        @(negedge clk);
        dmem_stall = 1'b1; reset = 1'b1;
        n = 0;
        while (!dmem_req && n < 100) begin @(posedge clk); #1; n++; end
        check("mid_dmem_req", {63'd0, dmem_req}, 64'd1);
        check("mid_dmem_addr", dmem_addr, 64'h0);
        check("mid_dmem_wdata", dmem_wdata, 64'd12);
        repeat (3) @(posedge clk);
        #3;
        check("mid_dmem_held", {63'd0, dmem_req & dmem_we}, 64'd1);
        reset = 1'b0; #1;
        check("async_dmem_req_drop", {63'd0, dmem_req}, 64'd0);
        check("async_dmem_we_drop", {63'd0, dmem_we}, 64'd0);

        @(negedge clk);
        dmem_stall = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check("refetch_req", {63'd0, imem_req}, 64'd1);
        check("refetch_addr", imem_addr, 64'h100);
        check("refetch_no_dmem", {63'd0, dmem_req}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
